// File: rtl/vdata_loader.sv
// vdata_loader: on each vsync start, fetches an 8x8 bitmap (8 bytes) and commits it to vdata in one cycle.
// Optional build macro VLOAD_TIMEOUT_EN adds a per-byte ack timeout with a sticky load_err flag.
module vdata_loader #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'h0000,
    parameter int                TIMEOUT   = 255
) (
    input  logic              dclk,
    input  logic              clr_n,
    input  logic              vsync,
    input  logic              page,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [63:0]       vdata,
    output logic              frame_done,
    output logic              load_err
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic              vsync_q_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [63:0]       shadow_r;
    logic [63:0]       vdata_r;
    logic              frame_done_r;
    logic [2:0]        idx_r;
    logic              start_s;
    logic              take_s;
    logic              last_s;
    logic              tmo_s;
    logic              wait_hit_s;
    logic [ADDR_W-1:0] base_s;

    // Page 1 sits 8 bytes above page 0; the sum wraps modulo 2^ADDR_W.
    assign base_s = BASE_ADDR + {{(ADDR_W-4){1'b0}}, page, 3'b000};

    // State register
    always_ff @(posedge dclk) begin
        if (!clr_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and transfer strobes
    always_comb begin
        state_nx_s = state_r;
        start_s    = 1'b0;
        take_s     = 1'b0;
        last_s     = 1'b0;
        tmo_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (vsync_q_r && !vsync) begin
                    start_s    = 1'b1;
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_ack) begin
                    take_s = 1'b1;
                    if (idx_r == 3'd7) begin
                        last_s     = 1'b1;
                        state_nx_s = ST_COMMIT;
                    end else begin
                        state_nx_s = ST_FETCH;
                    end
                end else if (wait_hit_s) begin
                    tmo_s      = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_COMMIT: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Request/address sequencing, byte capture and atomic commit
    always_ff @(posedge dclk) begin
        if (!clr_n) begin
            vsync_q_r    <= 1'b1;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            idx_r        <= 3'd0;
            shadow_r     <= 64'd0;
            vdata_r      <= 64'd0;
            frame_done_r <= 1'b0;
        end else begin
            vsync_q_r    <= vsync;
            frame_done_r <= 1'b0;
            if (start_s) begin
                mem_req_r  <= 1'b1;
                mem_addr_r <= base_s;
                idx_r      <= 3'd0;
            end else if (take_s) begin
                shadow_r[{idx_r, 3'b000} +: 8] <= mem_rdata;
                if (last_s) begin
                    mem_req_r <= 1'b0;
                    idx_r     <= 3'd0;
                end else begin
                    idx_r      <= idx_r + 3'd1;
                    mem_addr_r <= mem_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end else if (tmo_s) begin
                mem_req_r <= 1'b0;
            end else begin
                mem_req_r <= mem_req_r;
            end
            if (state_r == ST_COMMIT) begin
                vdata_r      <= shadow_r;
                frame_done_r <= 1'b1;
            end else begin
                vdata_r <= vdata_r;
            end
        end
    end

`ifdef VLOAD_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] wait_cnt_r;
    logic            load_err_r;

    // Per-byte wait counter, restarted by every new request
    always_ff @(posedge dclk) begin
        if (!clr_n) begin
            wait_cnt_r <= {TO_W{1'b0}};
        end else if (start_s || take_s) begin
            wait_cnt_r <= {TO_W{1'b0}};
        end else if (state_r == ST_FETCH) begin
            wait_cnt_r <= wait_cnt_r + TO_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Sticky timeout flag, cleared only by a successful commit
    always_ff @(posedge dclk) begin
        if (!clr_n) begin
            load_err_r <= 1'b0;
        end else if (tmo_s) begin
            load_err_r <= 1'b1;
        end else if (state_r == ST_COMMIT) begin
            load_err_r <= 1'b0;
        end else begin
            load_err_r <= load_err_r;
        end
    end

    assign wait_hit_s = (wait_cnt_r == TO_LAST);
    assign load_err   = load_err_r;
`else
    logic unused_timeout_s;

    assign unused_timeout_s = (TIMEOUT > 0);
    assign wait_hit_s       = 1'b0;
    assign load_err         = 1'b0;
`endif

    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign vdata      = vdata_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_vdata_loader.sv
// Directed bench for vdata_loader: reset, tied/delayed ack loads, mid-fetch reset, long stall or timeout.
module tb_vdata_loader;
    localparam logic [63:0] EXP_P0 = 64'h8040201008040201;
    localparam logic [63:0] EXP_P1 = 64'h00FFF00FC33C5AA5;

    logic        dclk = 1'b0;
    logic        clr_n;
    logic        vsync;
    logic        page;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [63:0] vdata;
    logic        frame_done;
    logic        load_err;

    logic [7:0]  mem [0:15];
    bit          ack_en;
    int          ack_delay;
    int          hold_n;
    int          req_cnt;
    bit          was_req;
    logic [15:0] last_addr;
    int          n_checks;
    int          n_fail;

    vdata_loader #(
        .ADDR_W   (16),
        .BASE_ADDR(16'h0000),
        .TIMEOUT  (4)
    ) dut (
        .dclk      (dclk),
        .clr_n     (clr_n),
        .vsync     (vsync),
        .page      (page),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .vdata     (vdata),
        .frame_done(frame_done),
        .load_err  (load_err)
    );

    always #5 dclk = ~dclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    // Leaves the sampling point just after the start edge N.
    task automatic start_load(input logic pg);
        vsync = 1'b1;
        tick();
        page  = pg;
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
    endtask

    // Memory responder: acks once the address has been held for more than ack_delay cycles.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        hold_n    = 0;
        was_req   = 1'b0;
        last_addr = 16'h0000;
        forever begin
            @(negedge dclk);
            if (mem_req === 1'b1) begin
                if (was_req && mem_addr == last_addr) begin
                    hold_n++;
                end else begin
                    hold_n = 1;
                    req_cnt++;
                end
            end else begin
                hold_n = 0;
            end
            was_req   = (mem_req === 1'b1);
            last_addr = mem_addr;
            mem_ack   = was_req && ack_en && (hold_n > ack_delay);
            mem_rdata = mem[mem_addr[3:0]];
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        req_cnt   = 0;
        ack_en    = 1'b0;
        ack_delay = 0;
        clr_n     = 1'b0;
        vsync     = 1'b1;
        page      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem[i] = 8'(1 << i);
        end
        mem[8]  = 8'hA5; mem[9]  = 8'h5A; mem[10] = 8'h3C; mem[11] = 8'hC3;
        mem[12] = 8'h0F; mem[13] = 8'hF0; mem[14] = 8'hFF; mem[15] = 8'h00;

        // Reset held for 3 cycles with vsync toggling
        for (int i = 0; i < 3; i++) begin
            vsync = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            check_eq("rst_req", mem_req, 64'd0);
        end
        check_eq("rst_vdata", vdata, 64'd0);
        check_eq("rst_addr", mem_addr, 64'd0);
        check_eq("rst_fd", frame_done, 64'd0);
        check_eq("rst_err", load_err, 64'd0);
        vsync = 1'b1;
        clr_n = 1'b1;
        tick();
        tick();
        check_eq("idle_req", mem_req, 64'd0);

        // Page 0, ack tied high
        ack_en    = 1'b1;
        ack_delay = 0;
        req_cnt   = 0;
        start_load(1'b0);
        for (int k = 0; k < 8; k++) begin
            check_eq("t2_req", mem_req, 64'd1);
            check_eq("t2_addr", mem_addr, 64'(k));
            check_eq("t2_fd_early", frame_done, 64'd0);
            tick();
        end
        check_eq("t2_req_drop", mem_req, 64'd0);
        check_eq("t2_vdata_hold", vdata, 64'd0);
        tick();
        check_eq("t2_vdata", vdata, EXP_P0);
        check_eq("t2_fd", frame_done, 64'd1);
        tick();
        check_eq("t2_fd_pulse", frame_done, 64'd0);
        check_eq("t2_vdata_keep", vdata, EXP_P0);
        check_eq("t2_reqs", req_cnt, 64'd8);

        // Page 1, ack after 3 wait cycles, spurious vsync edge mid-fetch
        ack_delay = 3;
        req_cnt   = 0;
        start_load(1'b1);
        page = 1'b0;
        for (int b = 0; b < 8; b++) begin
            for (int h = 0; h < 4; h++) begin
                if (b == 2 && h == 0) vsync = 1'b1;
                if (b == 3 && h == 0) vsync = 1'b0;
                check_eq("t3_addr", mem_addr, 64'(8 + b));
                check_eq("t3_req", mem_req, 64'd1);
                check_eq("t3_vdata_hold", vdata, EXP_P0);
                tick();
            end
        end
        check_eq("t3_req_drop", mem_req, 64'd0);
        check_eq("t3_fd_early", frame_done, 64'd0);
        tick();
        check_eq("t3_vdata", vdata, EXP_P1);
        check_eq("t3_fd", frame_done, 64'd1);
        tick();
        check_eq("t3_fd_pulse", frame_done, 64'd0);
        check_eq("t3_reqs", req_cnt, 64'd8);
        vsync = 1'b1;

        // Reset after byte 4 is acked, then a clean restart
        ack_delay = 0;
        start_load(1'b0);
        for (int k = 0; k < 5; k++) tick();
        check_eq("t4_addr_mid", mem_addr, 64'd5);
        clr_n = 1'b0;
        tick();
        check_eq("t4_req", mem_req, 64'd0);
        check_eq("t4_vdata", vdata, 64'd0);
        check_eq("t4_addr", mem_addr, 64'd0);
        clr_n = 1'b1;
        tick();
        start_load(1'b0);
        check_eq("t4_restart_addr", mem_addr, 64'd0);
        check_eq("t4_restart_req", mem_req, 64'd1);
        for (int k = 0; k < 8; k++) tick();
        check_eq("t4_req_drop", mem_req, 64'd0);
        tick();
        check_eq("t4_vdata_new", vdata, EXP_P0);
        check_eq("t4_fd", frame_done, 64'd1);

`ifdef VLOAD_TIMEOUT_EN
        // No ack: request abandoned after 4 wait cycles
        ack_en = 1'b0;
        start_load(1'b1);
        for (int k = 0; k < 4; k++) begin
            check_eq("to_req", mem_req, 64'd1);
            tick();
        end
        check_eq("to_req_drop", mem_req, 64'd0);
        check_eq("to_err", load_err, 64'd1);
        check_eq("to_vdata_keep", vdata, EXP_P0);
        check_eq("to_fd", frame_done, 64'd0);
        for (int k = 0; k < 3; k++) tick();
        check_eq("to_err_sticky", load_err, 64'd1);
        check_eq("to_idle_req", mem_req, 64'd0);
        ack_en = 1'b1;
        start_load(1'b1);
        for (int k = 0; k < 8; k++) tick();
        tick();
        check_eq("to_reload_vdata", vdata, EXP_P1);
        check_eq("to_reload_fd", frame_done, 64'd1);
        check_eq("to_err_clear", load_err, 64'd0);
`else
        // Ack withheld for 1000 cycles, then the load completes
        ack_en = 1'b0;
        start_load(1'b1);
        for (int k = 0; k < 1000; k++) tick();
        check_eq("stall_req", mem_req, 64'd1);
        check_eq("stall_addr", mem_addr, 64'd8);
        check_eq("stall_err", load_err, 64'd0);
        check_eq("stall_fd", frame_done, 64'd0);
        ack_en = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check_eq("stall_req_drop", mem_req, 64'd0);
        tick();
        check_eq("stall_vdata", vdata, EXP_P1);
        check_eq("stall_fd_done", frame_done, 64'd1);
        check_eq("stall_err_end", load_err, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
